// File: rtl/feeder_pkg.sv
// Shared types and defaults for the instruction feeder.
// FEEDER_STEP_EN adds the single-step PAUSE state.
package feeder_pkg;

  localparam logic [15:0] HALT_WORD_DEF = 16'hFFFF;
  localparam int          TIMEOUT_DEF   = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_ISSUE,
    S_EXEC,
`ifdef FEEDER_STEP_EN
    S_PAUSE,
`endif
    S_HALTED,
    S_ERROR
  } state_e;

  function automatic logic [15:0] sat_inc(
    input logic [15:0] v
  );
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/feeder_wdog.sv
// EXEC watchdog: counts enabled cycles, flags the TIMEOUT-th one.
// Cleared by the feeder whenever an instruction is about to issue.
module feeder_wdog
  import feeder_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign expired = enable && (cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear)
      cnt_d = '0;
    else if (enable && !expired)
      cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/inst_feeder.sv
// Fetches words from a 1-cycle ROM and issues them to a processor.
// Define FEEDER_STEP_EN for the Step input and PAUSE state.
module inst_feeder
  import feeder_pkg::*;
#(
  parameter int          AW        = 8,
  parameter logic [15:0] HALT_WORD = HALT_WORD_DEF,
  parameter int          TIMEOUT   = TIMEOUT_DEF
) (
  input  logic          Clock,
  input  logic          Resetn,
  input  logic          Start,
  output logic [AW-1:0] ADDR,
  input  logic [15:0]   ROM_DATA,
  output logic [15:0]   DIN,
  output logic          Run,
  input  logic          Done,
`ifdef FEEDER_STEP_EN
  input  logic          Step,
`endif
  output logic          Busy,
  output logic          Halted,
  output logic          Fault,
  output logic [15:0]   InstCount
);

  state_e        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [15:0]   din_q, din_d;
  logic [15:0]   cnt_q, cnt_d;
  logic          wd_clr, wd_en, wd_exp;

  feeder_wdog #(
    .TIMEOUT(TIMEOUT)
  ) u_wdog (
    .clk    (Clock),
    .rst_n  (Resetn),
    .clear  (wd_clr),
    .enable (wd_en),
    .expired(wd_exp)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    din_d   = din_q;
    cnt_d   = cnt_q;
    wd_clr  = 1'b0;
    wd_en   = 1'b0;
    unique case (state_q)
      S_IDLE, S_HALTED, S_ERROR: begin
        if (Start) begin
          state_d = S_FETCH;
          pc_d    = '0;
          cnt_d   = '0;
        end
      end
      S_FETCH: state_d = S_LOAD;
      S_LOAD: begin
        din_d = ROM_DATA;
        if (ROM_DATA == HALT_WORD) begin
          state_d = S_HALTED;
        end else begin
          state_d = S_ISSUE;
          wd_clr  = 1'b1;
        end
      end
      S_ISSUE: state_d = S_EXEC;
      S_EXEC: begin
        wd_en = !Done;
        if (Done) begin
          pc_d  = pc_q + AW'(1);
          cnt_d = sat_inc(cnt_q);
`ifdef FEEDER_STEP_EN
          state_d = S_PAUSE;
`else
          state_d = S_FETCH;
`endif
        end else if (wd_exp) begin
          state_d = S_ERROR;
        end
      end
`ifdef FEEDER_STEP_EN
      S_PAUSE: begin
        if (Step) state_d = S_FETCH;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      din_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      din_q   <= din_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ADDR      = pc_q;
  assign DIN       = din_q;
  assign InstCount = cnt_q;
  assign Run       = (state_q == S_ISSUE);
  assign Halted    = (state_q == S_HALTED);
  assign Fault     = (state_q == S_ERROR);
  assign Busy      = !(state_q inside {S_IDLE, S_HALTED, S_ERROR});

endmodule

// File: tb/tb_inst_feeder.sv
// Self-checking bench for inst_feeder: ROM model, processor
// responder and a slot-based reference model of the issue stream.
module tb_inst_feeder;

  localparam int          AW = 8;
  localparam logic [15:0] HW = 16'hFFFF;
  localparam int          TO = 16;
`ifdef FEEDER_STEP_EN
  localparam int PAUSE_C = 1;
`else
  localparam int PAUSE_C = 0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          done;
  logic [AW-1:0] addr;
  logic [15:0]   rom_data;
  logic [15:0]   din;
  logic          run, busy, halted, fault;
  logic [15:0]   icount;
`ifdef FEEDER_STEP_EN
  logic step_auto = 1'b1;
  logic step_man  = 1'b0;
  logic step;
  assign step = step_auto | step_man;
`endif

  inst_feeder #(
    .AW(AW), .HALT_WORD(HW), .TIMEOUT(TO)
  ) dut (
    .Clock    (clk),
    .Resetn   (rst_n),
    .Start    (start),
    .ADDR     (addr),
    .ROM_DATA (rom_data),
    .DIN      (din),
    .Run      (run),
    .Done     (done),
`ifdef FEEDER_STEP_EN
    .Step     (step),
`endif
    .Busy     (busy),
    .Halted   (halted),
    .Fault    (fault),
    .InstCount(icount)
  );

  always #5 clk = ~clk;

  logic [15:0] rom [256];
  int          lat [256];
  int          cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rom_data <= rom[addr];

  // Processor: Done on the lat-th cycle after the Run cycle.
  int dcnt = 0;
  logic noise = 1'b0;
  logic force_done = 1'b0;
  always @(negedge clk) begin
    done = (run & noise) | force_done;
    if (run === 1'b1) dcnt = lat[addr];
    else if (dcnt > 0) begin
      dcnt--;
      if (dcnt == 0) done = 1'b1;
    end
  end

  typedef struct {
    int            c;
    logic [15:0]   d;
    logic [AW-1:0] a;
    int            n;
  } iss_t;

  iss_t seen[$];
  iss_t expq[$];

  always @(negedge clk)
    if (run === 1'b1) seen.push_back('{cyc, din, addr, int'(icount)});

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] rw();
    logic [15:0] w = 16'($urandom);
    return (w == HW) ? 16'h0 : w;
  endfunction

  // Reference: each instruction occupies a slot of 3 + exec cycles.
  int            e_end, e_cnt;
  bit            e_h, e_f;
  logic [AW-1:0] e_pc;

  task automatic build_model(input int mx);
    int pc, slot, cnt;
    pc = 0; slot = 3; cnt = 0;
    e_h = 0; e_f = 0;
    expq.delete();
    for (int k = 0; k < mx; k++) begin
      if (rom[pc] == HW) begin e_h = 1; break; end
      expq.push_back('{slot, rom[pc], AW'(pc), cnt});
      if (lat[pc] > TO) begin
        e_f = 1; slot += TO + 1; break;
      end
      slot += lat[pc] + 3 + PAUSE_C;
      cnt = (cnt < 65535) ? cnt + 1 : cnt;
      pc = (pc + 1) % 256;
    end
    e_end = slot; e_cnt = cnt; e_pc = AW'(pc);
  endtask

  task automatic run_case(input string nm, input int mx,
                          input bit term, input int pk);
    int t0, endc, poke, sz;
    build_model(mx);
    seen.delete();
    poke = pk; endc = -1;
    @(negedge clk);
    start = 1'b1; t0 = cyc;
    for (int k = 0; k < e_end + 30; k++) begin
      @(negedge clk);
      start = (poke > 0 && seen.size() > 0);
      if (start) poke--;
      if (halted || fault) begin endc = cyc - t0; break; end
      if (!term && seen.size() >= mx) break;
    end
    start = 1'b0;
    if (term) begin
      chk({nm, " end cycle"}, endc, e_end);
      chk({nm, " halted"}, halted, e_h);
      chk({nm, " fault"}, fault, e_f);
      chk({nm, " busy"}, busy, 0);
      chk({nm, " addr"}, addr, e_pc);
      chk({nm, " count"}, icount, e_cnt);
      chk({nm, " runs"}, seen.size(), expq.size());
    end else begin
      chk({nm, " runs"}, seen.size() >= mx, 1);
    end
    sz = (seen.size() < expq.size()) ? seen.size() : expq.size();
    for (int i = 0; i < sz; i++) begin
      chk($sformatf("%s din%0d", nm, i), seen[i].d, expq[i].d);
      chk($sformatf("%s adr%0d", nm, i), seen[i].a, expq[i].a);
      chk($sformatf("%s cyc%0d", nm, i), seen[i].c - t0, expq[i].c);
      chk($sformatf("%s cnt%0d", nm, i), seen[i].n, expq[i].n);
    end
    if (term) begin
      force_done = 1'b1;
      repeat (4) @(negedge clk);
      force_done = 1'b0;
      chk({nm, " hold h"}, halted, e_h);
      chk({nm, " hold f"}, fault, e_f);
      chk({nm, " hold cnt"}, icount, e_cnt);
      chk({nm, " hold runs"}, seen.size(), expq.size());
    end else begin
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
    end
  endtask

  typedef struct {
    int          n;
    logic [15:0] w0;
    int          lt;
    int          mx;
    int          pk;
    int          ecnt;
    bit          eh;
    bit          ef;
  } vec_t;

  vec_t tab[6];

  initial begin
    tab[0] = '{1,   16'h1205, 1,  8,   0, 1, 1, 0};
    tab[1] = '{3,   16'h2001, 3,  8,   2, 3, 1, 0};
    tab[2] = '{0,   16'h0000, 1,  8,   0, 0, 1, 0};
    tab[3] = '{2,   16'h3003, 16, 8,   0, 2, 1, 0};
    tab[4] = '{2,   16'h4004, 17, 8,   0, 0, 0, 1};
    tab[5] = '{256, 16'h5005, 1,  260, 0, 0, 0, 0};

    for (int i = 0; i < 256; i++) begin
      rom[i] = HW; lat[i] = 1;
    end

    repeat (3) @(negedge clk);
    chk("rst run", run, 0);
    chk("rst busy", busy, 0);
    chk("rst halted", halted, 0);
    chk("rst fault", fault, 0);
    chk("rst count", icount, 0);
    chk("rst din", din, 0);
    chk("rst addr", addr, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle busy", busy, 0);
    chk("idle runs", seen.size(), 0);

    for (int v = 0; v < 6; v++) begin
      for (int i = 0; i < 256; i++) begin
        rom[i] = (i >= tab[v].n) ? HW : (i == 0) ? tab[v].w0 : rw();
        lat[i] = tab[v].lt;
      end
      run_case($sformatf("vec%0d", v), tab[v].mx,
               tab[v].eh | tab[v].ef, tab[v].pk);
      if (tab[v].eh | tab[v].ef) begin
        chk($sformatf("vec%0d tcnt", v), icount, tab[v].ecnt);
        chk($sformatf("vec%0d th", v), halted, tab[v].eh);
        chk($sformatf("vec%0d tf", v), fault, tab[v].ef);
      end
    end

    for (int r = 0; r < 20; r++) begin
      int n;
      n = $urandom_range(0, 5);
      for (int i = 0; i < 256; i++) begin
        rom[i] = (i < n) ? rw() : HW;
        lat[i] = ($urandom_range(0, 7) == 0) ? TO + 1
                 : $urandom_range(1, TO);
      end
      noise = 1'($urandom_range(0, 1));
      run_case($sformatf("rnd%0d", r), 16, 1, 0);
    end
    noise = 1'b0;

    for (int i = 0; i < 256; i++) begin
      rom[i] = 16'h0A00 + 16'(i); lat[i] = 10;
    end
    lat[0] = 1; rom[5] = HW;
    seen.delete();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int k = 0; k < 40 && seen.size() < 2; k++) @(negedge clk);
    chk("ar runs", seen.size(), 2);
    repeat (3) @(negedge clk);
    chk("ar pre cnt", icount, 1);
    chk("ar pre busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar run", run, 0);
    chk("ar busy", busy, 0);
    chk("ar cnt", icount, 0);
    chk("ar addr", addr, 0);
    chk("ar din", din, 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("ar idle busy", busy, 0);
    chk("ar idle addr", addr, 0);
    chk("ar idle runs", seen.size(), 2);

`ifdef FEEDER_STEP_EN
    for (int i = 0; i < 256; i++) begin
      rom[i] = (i < 3) ? 16'h5100 + 16'(i) : HW; lat[i] = 2;
    end
    step_auto = 1'b0;
    seen.delete();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int s = 1; s <= 3; s++) begin
      for (int k = 0; k < 30 && seen.size() < s; k++) @(negedge clk);
      repeat (8) @(negedge clk);
      chk($sformatf("step runs%0d", s), seen.size(), s);
      chk($sformatf("step busy%0d", s), busy, 1);
      chk($sformatf("step cnt%0d", s), icount, s);
      step_man = 1'b1;
      @(negedge clk);
      step_man = 1'b0;
    end
    for (int k = 0; k < 10 && !halted; k++) @(negedge clk);
    chk("step halted", halted, 1);
    chk("step total", seen.size(), 3);
    step_auto = 1'b1;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
